hazard_unit: RTL and testbench

Data-hazard and control-hazard resolver for the 5-stage pipelined RV32I core. Sits beside the controller. It consumes the controller's `RegWrite_M`, `RegWrite_W` and `PCSrcE`, plus decode-stage register indices, and drives the forwarding muxes and the stall/flush controls of the pipeline registers. It keeps its own pipelined copies of register tags (E/M/W) so the datapath does not need to export them. Saturating stall and flush counters are included for performance debug.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_unit_if.sv | 34 +++
 rtl/hazard_tag_pipe.sv | 27 ++
 rtl/hazard_unit.sv | 65 ++++++
 tb/tb_hazard_unit.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard resolver.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_t;

  // Register tags carried by the instruction as it moves from D into E.
  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     load;
  } e_tags_t;

  // Operand source select: the younger producer in M beats W, x0 never forwards.
  function automatic forward_t fwd_sel(input reg_idx_t rs, input reg_idx_t rd_m,
                                       input reg_idx_t rd_w, input logic rw_m,
                                       input logic rw_w);
    forward_t sel;
    sel = FWD_RF;
    if (rs != REG_X0 && rw_m && rs == rd_m) begin
      sel = FWD_M;
    end else if (rs != REG_X0 && rw_w && rs == rd_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard resolver connection: D-stage/controller inputs and forward/stall/flush outputs.
interface hazard_unit_if #(parameter int unsigned CNT_W = 32);
  import hazard_pkg::*;

  reg_idx_t   Rs1_D;
  reg_idx_t   Rs2_D;
  reg_idx_t   Rd_D;
  logic       ResultSrc_D0;
  logic       RegWrite_M;
  logic       RegWrite_W;
  logic       PCSrcE;

  forward_t   Forward_AE;
  forward_t   Forward_BE;
  logic       Stall_F;
  logic       Stall_D;
  logic       Flush_D;
  logic       Flush_E;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  Rs1_D, Rs2_D, Rd_D, ResultSrc_D0, RegWrite_M, RegWrite_W, PCSrcE,
    output Forward_AE, Forward_BE, Stall_F, Stall_D, Flush_D, Flush_E,
           stall_count, flush_count
  );

  modport master (
    output Rs1_D, Rs2_D, Rd_D, ResultSrc_D0, RegWrite_M, RegWrite_W, PCSrcE,
    input  Forward_AE, Forward_BE, Stall_F, Stall_D, Flush_D, Flush_E,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_tag_pipe.sv
// Private E/M/W copies of register tags; a flush turns the E slot into a bubble.
module hazard_tag_pipe
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_e,
  input  e_tags_t  tags_d,
  output e_tags_t  tags_e,
  output reg_idx_t rd_m,
  output reg_idx_t rd_w
);

  // E still advances during a load-use stall; the bubble comes from flush_e.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags_e <= '0;
      rd_m   <= REG_X0;
      rd_w   <= REG_X0;
    end else begin
      tags_e <= flush_e ? e_tags_t'('0) : tags_d;
      rd_m   <= tags_e.rd;
      rd_w   <= rd_m;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Data/control hazard resolver for the 5-stage RV32I pipeline: forwarding,
// load-use stall, branch flush and saturating performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hz
);

  e_tags_t          tags_d;
  e_tags_t          tags_e;
  reg_idx_t         rd_m;
  reg_idx_t         rd_w;
  logic             lw_stall;
  logic             flush_e;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign tags_d = '{rs1: hz.Rs1_D, rs2: hz.Rs2_D, rd: hz.Rd_D, load: hz.ResultSrc_D0};

  hazard_tag_pipe u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush_e (flush_e),
    .tags_d  (tags_d),
    .tags_e  (tags_e),
    .rd_m    (rd_m),
    .rd_w    (rd_w)
  );

  // A taken branch in E wins over a load-use stall.
  assign lw_stall = tags_e.load && (tags_e.rd != REG_X0) &&
                    ((tags_e.rd == hz.Rs1_D) || (tags_e.rd == hz.Rs2_D)) &&
                    !hz.PCSrcE;
  assign flush_e  = lw_stall | hz.PCSrcE;

  assign hz.Forward_AE = fwd_sel(tags_e.rs1, rd_m, rd_w, hz.RegWrite_M, hz.RegWrite_W);
  assign hz.Forward_BE = fwd_sel(tags_e.rs2, rd_m, rd_w, hz.RegWrite_M, hz.RegWrite_W);
  assign hz.Stall_F    = lw_stall;
  assign hz.Stall_D    = lw_stall;
  assign hz.Flush_D    = hz.PCSrcE;
  assign hz.Flush_E    = flush_e;

  // Event counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (hz.PCSrcE && flush_cnt != {CNT_W{1'b1}}) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: driver queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    string name;
    int    fa;
    int    fb;
    int    st;
    int    fd;
    int    fe;
    int    sc;
    int    fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input int rs1, input int rs2, input int rd, input int ld,
                       input int rwm, input int rww, input int pcs);
    @(posedge clk);
    #1;
    hz.Rs1_D        = 5'(rs1);
    hz.Rs2_D        = 5'(rs2);
    hz.Rd_D         = 5'(rd);
    hz.ResultSrc_D0 = 1'(ld);
    hz.RegWrite_M   = 1'(rwm);
    hz.RegWrite_W   = 1'(rww);
    hz.PCSrcE       = 1'(pcs);
  endtask

  task automatic expect_out(input string name, input int fa, input int fb, input int st,
                            input int fd, input int fe, input int sc, input int fc);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.st = st;
    e.fd = fd; e.fe = fe; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expected record per checked cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "Forward_AE",  int'(hz.Forward_AE), e.fa);
        cmp(e.name, "Forward_BE",  int'(hz.Forward_BE), e.fb);
        cmp(e.name, "Stall_F",     int'(hz.Stall_F),    e.st);
        cmp(e.name, "Stall_D",     int'(hz.Stall_D),    e.st);
        cmp(e.name, "Flush_D",     int'(hz.Flush_D),    e.fd);
        cmp(e.name, "Flush_E",     int'(hz.Flush_E),    e.fe);
        cmp(e.name, "stall_count", int'(hz.stall_count), e.sc);
        cmp(e.name, "flush_count", int'(hz.flush_count), e.fc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    hz.Rs1_D        = '0;
    hz.Rs2_D        = '0;
    hz.Rd_D         = '0;
    hz.ResultSrc_D0 = 1'b0;
    hz.RegWrite_M   = 1'b0;
    hz.RegWrite_W   = 1'b0;
    hz.PCSrcE       = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0);                    expect_out("reset",       0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 0, 0, 0); reset = 1'b1;      expect_out("idle",        0, 0, 0, 0, 0, 0, 0);
    // Producer of x5 then consumer: forward from M two cycles later.
    drive(5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);                    expect_out("fwd_m",       2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // x7 written by two older instructions: M beats W.
    drive(0, 0, 7, 0, 0, 0, 0);
    drive(0, 0, 7, 0, 0, 0, 0);
    drive(0, 7, 7, 0, 0, 0, 0);
    drive(0, 7, 0, 0, 1, 1, 0);                    expect_out("prio_m",      0, 2, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);                    expect_out("prio_w",      0, 1, 0, 0, 0, 0, 0);
    // x0 guards: no forward of x0, no stall for a load to x0.
    drive(0, 0, 0, 1, 1, 1, 0);                    expect_out("x0_fwd",      0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);                    expect_out("x0_load",     0, 0, 0, 0, 0, 0, 0);
    // Load to x3 followed by a reader of x3.
    drive(0, 0, 3, 1, 0, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 0);                    expect_out("lduse",       0, 0, 1, 0, 1, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 0);                    expect_out("lduse_clr",   0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);                    expect_out("lduse_fwd_w", 0, 1, 0, 0, 0, 1, 0);
    // Taken branch with a load-use pattern present.
    drive(0, 0, 4, 1, 0, 0, 0);
    drive(4, 0, 0, 0, 0, 0, 1);                    expect_out("br_taken",    0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);                    expect_out("br_after",    0, 0, 0, 0, 0, 1, 1);
    // Chain of loads to x6, each reading x6: a stall every other cycle.
    drive(6, 0, 6, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(6, 0, 6, 1, 0, 0, 0);
      expect_out($sformatf("sat_%0d", i), 0, 0, 1, 0, 1, (i + 1 > 3) ? 3 : i + 1, 1);
      if (i < 4) drive(6, 0, 6, 1, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);                    expect_out("sat_end",     0, 0, 0, 0, 0, 3, 1);
    // Forward in flight, then asynchronous reset mid-cycle.
    drive(0, 0, 9, 0, 0, 0, 0);
    drive(9, 9, 9, 0, 0, 0, 0);
    drive(9, 9, 0, 0, 1, 0, 0);                    expect_out("fwd_pre_rst", 2, 2, 0, 0, 0, 3, 1);
    drive(0, 0, 0, 0, 1, 0, 0); #1 reset = 1'b0;   expect_out("async_rst",   0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0); reset = 1'b1;      expect_out("post_rst",    0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
